// File: rtl/key_feeder_if.sv
// Host-side strobes and watchdog-side serial key lines of the key feeder.
interface key_feeder_if #(
  parameter int unsigned KEY_BITS = 64
);
  logic                key_wr;
  logic [KEY_BITS-1:0] key_din;
  logic                key_clr;
  logic                en;
  logic                sclk;
  logic                sdat;
  logic                busy;
  logic [15:0]         frame_cnt;

  modport master (
    output key_wr, key_din, key_clr,
    input  en, sclk, sdat, busy, frame_cnt
  );

  modport slave (
    input  key_wr, key_din, key_clr,
    output en, sclk, sdat, busy, frame_cnt
  );
endinterface

// File: rtl/key_feeder.sv
// Serial key sequencer: shifts the stored key MSB-first into the watchdog key
// shift register and periodically re-sends it so the watchdog keeps matching.
module key_feeder #(
  parameter int unsigned KEY_BITS       = 64,
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned REFRESH_CYCLES = 25000000
) (
  input logic         clk,
  input logic         rst,
  key_feeder_if.slave bus
);

  localparam int unsigned BitW = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
  localparam logic [7:0]      PhaseLast   = 8'(CLK_DIV - 1);
  localparam logic [31:0]     RefreshLast = 32'(REFRESH_CYCLES - 1);
  localparam logic [BitW-1:0] BitFirst    = BitW'(KEY_BITS - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e              state_q;
  logic [7:0]          phase_q;
  logic [BitW-1:0]     bit_q;
  logic [BitW-1:0]     bit_nxt;
  logic [31:0]         refresh_q;
  logic [KEY_BITS-1:0] key_q;
  logic [KEY_BITS-1:0] shadow_q;
  logic                key_valid_q;
  logic                pending_q;
  logic                en_q;
  logic                sclk_q;
  logic                sdat_q;
  logic                busy_q;
  logic [15:0]         frame_cnt_q;
  logic                start;

  assign bit_nxt = bit_q - BitW'(1);

  // A frame starts on a fresh key or when the refresh period has elapsed;
  // a clear in the same cycle suppresses the start.
  assign start = !bus.key_clr &&
                 (pending_q || (key_valid_q && (refresh_q == RefreshLast)));

  // Key register, frame sequencer and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      bit_q       <= '0;
      refresh_q   <= '0;
      key_q       <= '0;
      shadow_q    <= '0;
      key_valid_q <= 1'b0;
      pending_q   <= 1'b0;
      en_q        <= 1'b0;
      sclk_q      <= 1'b0;
      sdat_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      // Clear has priority over a simultaneous write.
      if (bus.key_clr) begin
        key_q       <= '0;
        key_valid_q <= 1'b0;
        pending_q   <= 1'b0;
      end else if (bus.key_wr) begin
        key_q       <= bus.key_din;
        key_valid_q <= 1'b1;
        pending_q   <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StLow;
            phase_q   <= '0;
            bit_q     <= BitFirst;
            shadow_q  <= key_q;
            en_q      <= 1'b1;
            sclk_q    <= 1'b0;
            sdat_q    <= key_q[KEY_BITS-1];
            busy_q    <= 1'b1;
            refresh_q <= '0;
            // A write landing on the start edge keeps its request alive.
            if (!bus.key_wr) pending_q <= 1'b0;
          end else if (key_valid_q && !bus.key_clr) begin
            refresh_q <= refresh_q + 32'd1;
          end else begin
            refresh_q <= '0;
          end
        end

        StLow: begin
          if (bus.key_clr) begin
            state_q <= StIdle;
            en_q    <= 1'b0;
            sclk_q  <= 1'b0;
            sdat_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (phase_q == PhaseLast) begin
            state_q <= StHigh;
            phase_q <= '0;
            sclk_q  <= 1'b1;
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end

        StHigh: begin
          if (bus.key_clr) begin
            state_q <= StIdle;
            en_q    <= 1'b0;
            sclk_q  <= 1'b0;
            sdat_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (phase_q == PhaseLast) begin
            phase_q <= '0;
            sclk_q  <= 1'b0;
            if (bit_q == '0) begin
              state_q <= StDone;
              en_q    <= 1'b0;
              sdat_q  <= 1'b0;
            end else begin
              state_q <= StLow;
              bit_q   <= bit_nxt;
              sdat_q  <= shadow_q[bit_nxt];
            end
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end

        StDone: begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          refresh_q <= '0;
          if (frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
        end

        default: begin
          state_q <= StIdle;
          en_q    <= 1'b0;
          sclk_q  <= 1'b0;
          sdat_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.en        = en_q;
  assign bus.sclk      = sclk_q;
  assign bus.sdat      = sdat_q;
  assign bus.busy      = busy_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_key_feeder.sv
// Directed bench for key_feeder: frame shape, refresh period, rewrite, abort,
// simultaneous strobes, reset and counter saturation.
module tb_key_feeder;

  localparam int unsigned KeyBits = 64;
  localparam logic [63:0] Key1    = 64'h0123456789ABCDEF;
  localparam logic [63:0] Key2    = 64'hFFFF0000FFFF0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  key_feeder_if #(.KEY_BITS(KeyBits)) bus ();

  key_feeder #(
    .KEY_BITS       (KeyBits),
    .CLK_DIV        (2),
    .REFRESH_CYCLES (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver model: shift in sdat on each sclk rise while en is high.
  logic        mon_clr;
  logic        sclk_prev;
  logic [63:0] mon_q;
  int          rises;

  always @(posedge clk) begin
    if (mon_clr) begin
      mon_q <= '0;
      rises <= 0;
    end else if (bus.en && bus.sclk && !sclk_prev) begin
      mon_q <= {mon_q[62:0], bus.sdat};
      rises <= rises + 1;
    end
    sclk_prev <= bus.sclk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Count idle cycles until en rises (bounded); receiver model cleared meanwhile.
  task automatic wait_start(input string tag, input int exp_gap);
    int c;
    c = 0;
    mon_clr = 1'b1;
    while (!bus.en && c < 2000) begin
      c++;
      @(negedge clk);
    end
    mon_clr = 1'b0;
    check(tag, 64'(c), 64'(exp_gap));
  endtask

  // Follow a frame from its first en cycle; optionally rewrite the key at
  // cycle wr_at of the frame.
  task automatic run_frame(input string tag, input logic [63:0] exp_key,
                           input logic [15:0] exp_cnt, input int wr_at,
                           input logic [63:0] wr_key);
    int c;
    c = 0;
    while (bus.en && c < 2000) begin
      bus.key_wr  = (c == wr_at);
      bus.key_din = wr_key;
      c++;
      @(negedge clk);
    end
    bus.key_wr = 1'b0;
    check({tag, "_len"}, 64'(c), 64'd256);
    check({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
    check({tag, "_rises"}, 64'(rises), 64'd64);
    check({tag, "_key"}, mon_q, exp_key);
    @(negedge clk);
    check({tag, "_cnt"}, 64'(bus.frame_cnt), 64'(exp_cnt));
    check({tag, "_busy_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int hi;
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    mon_clr     = 1'b1;
    bus.key_wr  = 1'b0;
    bus.key_clr = 1'b0;
    bus.key_din = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_en", 64'(bus.en), 64'd0);
    check("rst_sclk", 64'(bus.sclk), 64'd0);
    check("rst_sdat", 64'(bus.sdat), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_cnt", 64'(bus.frame_cnt), 64'd0);

    // Initial load: en rises two edges after the write.
    bus.key_wr  = 1'b1;
    bus.key_din = Key1;
    @(negedge clk);
    bus.key_wr = 1'b0;
    check("lat_1", 64'(bus.en), 64'd0);
    @(negedge clk);
    check("lat_2", 64'(bus.en), 64'd1);
    check("lat_busy", 64'(bus.busy), 64'd1);
    mon_clr = 1'b0;
    run_frame("f1", Key1, 16'd1, -1, '0);

    // Periodic refresh.
    wait_start("gap2", 100);
    run_frame("f2", Key1, 16'd2, -1, '0);
    wait_start("gap3", 100);
    run_frame("f3", Key1, 16'd3, -1, '0);

    // Rewrite at bit 30 (33 bits of 4 cycles already sent).
    wait_start("gap4", 100);
    run_frame("f4", Key1, 16'd4, 132, Key2);
    wait_start("gap5", 1);
    run_frame("f5", Key2, 16'd5, -1, '0);

    // Abort at bit 10 (53 bits already sent).
    wait_start("gap6", 100);
    repeat (212) @(negedge clk);
    bus.key_clr = 1'b1;
    @(negedge clk);
    bus.key_clr = 1'b0;
    check("abort_en", 64'(bus.en), 64'd0);
    check("abort_sclk", 64'(bus.sclk), 64'd0);
    check("abort_sdat", 64'(bus.sdat), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_cnt", 64'(bus.frame_cnt), 64'd5);
    hi = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.en) hi++;
    end
    check("abort_quiet", 64'(hi), 64'd0);

    // Simultaneous write and clear: clear wins.
    bus.key_wr  = 1'b1;
    bus.key_clr = 1'b1;
    bus.key_din = Key1;
    @(negedge clk);
    bus.key_wr  = 1'b0;
    bus.key_clr = 1'b0;
    hi = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.en) hi++;
    end
    check("both_quiet", 64'(hi), 64'd0);
    check("both_valid", 64'(dut.key_valid_q), 64'd0);

    // Reset mid-frame.
    bus.key_wr  = 1'b1;
    bus.key_din = Key2;
    @(negedge clk);
    bus.key_wr = 1'b0;
    @(negedge clk);
    check("rst_start", 64'(bus.en), 64'd1);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstm_en", 64'(bus.en), 64'd0);
    check("rstm_sclk", 64'(bus.sclk), 64'd0);
    check("rstm_sdat", 64'(bus.sdat), 64'd0);
    check("rstm_busy", 64'(bus.busy), 64'd0);
    check("rstm_cnt", 64'(bus.frame_cnt), 64'd0);
    hi = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.en) hi++;
    end
    check("rstm_quiet", 64'(hi), 64'd0);

    // Saturation of the frame counter.
    force dut.frame_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    check("sat_pre", 64'(bus.frame_cnt), 64'hFFFE);
    mon_clr     = 1'b1;
    bus.key_wr  = 1'b1;
    bus.key_din = Key2;
    @(negedge clk);
    bus.key_wr = 1'b0;
    @(negedge clk);
    check("sat_start", 64'(bus.en), 64'd1);
    mon_clr = 1'b0;
    run_frame("s1", Key2, 16'hFFFF, -1, '0);
    wait_start("gap_s2", 100);
    run_frame("s2", Key2, 16'hFFFF, -1, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_feeder.md
Name: key_feeder

Overview:
- Sequencer that drives the serial key interface (en, sclk, sdat) of the watchdog's key shift register from a host-written 64-bit key.
- Shifts the key in MSB-first frames, then repeats each frame periodically so the watchdog's key match stays asserted.
- Sits between the host register block and the watchdog, in the system clock domain.

Parameters:
- KEY_BITS, 64, key/frame length in bits.
- CLK_DIV, 4, clk cycles per sclk phase (low and high each); legal range 1..255.
- REFRESH_CYCLES, 25000000, clk cycles from end of one frame to start of the next auto-refresh frame; legal range 1..2^32-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_wr  in  1  one-cycle strobe: load key_din as the new key.
- key_din  in  KEY_BITS  key value, sampled when key_wr=1.
- key_clr  in  1  one-cycle strobe: invalidate key, abort any frame.
- en  out  1  frame enable to the watchdog shift register.
- sclk  out  1  serial clock; receiver shifts on its rising edge.
- sdat  out  1  serial data, MSB of the key first.
- busy  out  1  high while a frame is in progress.
- frame_cnt  out  16  completed frames, saturating at 16'hFFFF.

Behaviour:
- Reset values: en=0, sclk=0, sdat=0, busy=0, frame_cnt=0, key_valid=0, pending=0, refresh counter=0, state IDLE.
- All outputs are registered. Receiver contract: q <= {q[KEY_BITS-2:0], si} on posedge sclk when en=1. After a full frame, receiver q equals the key.
- States:
  - IDLE: outputs low. Go to LOW with bit index = KEY_BITS-1 when (a) pending=1, or (b) key_valid=1 and refresh counter = REFRESH_CYCLES-1.
  - LOW: en=1, sclk=0, sdat=shadow[bit]. Hold for CLK_DIV cycles, then go to HIGH.
  - HIGH: en=1, sclk=1, sdat unchanged. Hold for CLK_DIV cycles. If bit=0, go to DONE; otherwise decrement bit and go to LOW.
  - DONE: one cycle with en=0, sclk=0. Increment frame_cnt (saturating), clear refresh counter, go to IDLE.
- Frame timing:
  - sdat is stable for CLK_DIV cycles before and CLK_DIV cycles after each sclk rise.
  - Frame length is 2*CLK_DIV*KEY_BITS cycles of en=1.
  - busy=1 in LOW, HIGH and DONE.
- Shadow register: loaded from the key register at the IDLE->LOW transition only. The key in flight never changes mid-frame.
- key_wr:
  - Key register takes key_din; key_valid and pending are set.
  - In IDLE: the frame starts on the next cycle. The first frame begins exactly 2 cycles after the key_wr cycle (en rises then). Consumes pending.
  - Mid-frame: the current frame completes with the old key. The new frame starts the cycle after DONE and then clears pending.
- Refresh counter: counts in IDLE only while key_valid=1; held at 0 otherwise.
- key_clr:
  - Clears key_valid and pending and zeroes the key register.
  - In LOW or HIGH: abort next cycle to IDLE with en=sclk=sdat=0. frame_cnt is not incremented.
- key_wr and key_clr in the same cycle: key_clr wins and key_wr is ignored.
- rst mid-frame: immediate return to reset values on the next edge. The partial frame is dropped.
- The counters are sized for the parameter maxima: phase counter 8 bits, bit index ceil(log2(KEY_BITS)), refresh counter 32 bits.

Test Plan:
- Initial load (CLK_DIV=2, REFRESH_CYCLES=100): reset, then key_wr with 64'h0123456789ABCDEF -> en high for 256 cycles; 64 sclk rises; model shift register q=64'h0123456789ABCDEF; frame_cnt=1; busy drops after DONE.
- Refresh: after the first frame, no stimulus -> the next frame's en rises exactly 100 cycles after DONE; the same 64 bits are repeated; frame_cnt=2, then 3 after the next period.
- Mid-frame rewrite: key_wr 64'hFFFF0000FFFF0000 at bit 30 of a frame carrying 64'h0123456789ABCDEF -> the current frame completes with the old key; the following frame starts 1 cycle after DONE with the new key; q=64'hFFFF0000FFFF0000.
- Abort: key_clr at bit 10 -> the next cycle has en=sclk=sdat=0; frame_cnt unchanged; no further frames for 1000 cycles.
- Simultaneous strobes: key_wr and key_clr in the same cycle while IDLE -> no frame; key_valid=0.
- Reset and saturation: rst mid-frame -> all outputs 0 on the next cycle. With frame_cnt forced to 16'hFFFE, two frames -> frame_cnt stays at 16'hFFFF.
